fpu_result_uart_tx: RTL

- UART 8N1 transmitter. It is the return path for the single-precision FPU top.
- It accepts one 32-bit FPU result through a valid/ready handshake and serialises it as four bytes, least-significant byte first.
- The bit period comes from the same runtime CLKS_PER_BIT value that drives the FPU's UART receiver.
- It sits beside the FPU FSM top and drives a user GPIO pad, so results can be read back over serial instead of the 32 parallel pads.

---
 rtl/fpu_uart_pkg.sv | 23 ++
 rtl/uart_tx_byte.sv | 128 ++++++++++++
 rtl/fpu_result_uart_tx.sv | 106 ++++++++++
 3 files changed

// File: rtl/fpu_uart_pkg.sv
// fpu_uart_pkg
//   Definitions shared by the FPU UART transmit and receive paths: the line
//   state encoding, the 8N1 frame constants and the default bit period.
package fpu_uart_pkg;

  // Data bits per 8N1 frame
  localparam int UART_DATA_BITS = 8;

  // Line level while nothing is being sent (and during the stop bit)
  localparam logic UART_IDLE_LVL = 1'b1;

  // Power-on bit period, in clocks. The receiver uses the same value.
  localparam int UART_DEFAULT_CPB = 348;

  // Serialiser line state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
//   Single-byte 8N1 serialiser. A start request loads byte_i and sends
//   start bit, 8 data bits LSB first, then the stop bit. Each bit lasts cpb_i
//   clocks. A start request seen in the last stop-bit cycle chains straight
//   into the next frame, so bytes can be sent with no idle gap.
//
// Ports
//   clk      system clock
//   rst      synchronous active-high reset
//   start_i  load byte_i and begin a frame (honoured in IDLE or last STOP cycle)
//   byte_i   byte to send
//   cpb_i    clocks per bit, must be non-zero, held stable for the frame
//   tx_o     registered serial line
//   busy_o   a frame is in progress
//   done_o   combinational strobe during the final cycle of the stop bit
module uart_tx_byte
  import fpu_uart_pkg::*;
#(
  parameter int CPB_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [7:0]           byte_i,
  input  logic [CPB_WIDTH-1:0] cpb_i,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int BIT_W = $clog2(UART_DATA_BITS);

  uart_state_e          state_q, state_d;
  logic [CPB_WIDTH-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [7:0]           sh_q, sh_d;
  logic                 tx_q, tx_d;
  logic                 baud_end;

  // Interval ends on the last of cpb_i cycles
  assign baud_end = (cnt_q == (cpb_i - CPB_WIDTH'(1)));

  // tx_d always carries the level for the state being entered, so the line
  // changes on the same edge as the state and comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;

    if (state_q == IDLE) begin
      cnt_d = '0;
      tx_d  = UART_IDLE_LVL;
    end else begin
      cnt_d = baud_end ? '0 : cnt_q + CPB_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = START;
          sh_d    = byte_i;
          bit_d   = '0;
          tx_d    = ~UART_IDLE_LVL;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        // sh_q[0] is the bit on the line; shift so the next one moves down
        if (baud_end) begin
          if (bit_q == BIT_W'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
            tx_d    = UART_IDLE_LVL;
          end else begin
            bit_d = bit_q + BIT_W'(1);
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (start_i) begin
            state_d = START;
            sh_d    = byte_i;
            bit_d   = '0;
            tx_d    = ~UART_IDLE_LVL;
          end else begin
            state_d = IDLE;
            tx_d    = UART_IDLE_LVL;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = UART_IDLE_LVL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == STOP) && baud_end;

endmodule

// File: rtl/fpu_result_uart_tx.sv
// fpu_result_uart_tx
//   Return path for the FPU: accepts one result word over valid/ready and
//   sends it as DATA_BYTES back-to-back 8N1 bytes, least-significant first.
//   The bit period is sampled from CLKS_PER_BIT when the word is accepted.
//
// Ports
//   clk             system clock
//   rst             synchronous active-high reset (aborts a word silently)
//   CLKS_PER_BIT    clocks per bit; 0 is treated as 1
//   result_i        word to send
//   result_valid_i  result_i is valid
//   result_ready_o  idle and able to take a word
//   tx_o            registered serial line, idle high
//   busy_o          a word is being sent
//   done_o          one-cycle pulse after the last stop bit of a word
module fpu_result_uart_tx
  import fpu_uart_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int CPB_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CPB_WIDTH-1:0]    CLKS_PER_BIT,
  input  logic [8*DATA_BYTES-1:0] result_i,
  input  logic                    result_valid_i,
  output logic                    result_ready_o,
  output logic                    tx_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int DW    = 8 * DATA_BYTES;
  localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  logic [DW-1:0]        sh_q, sh_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CPB_WIDTH-1:0] cpb_q, cpb_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic accept, byte_done, last_byte, more, start;

  assign accept    = result_valid_i & ~busy_q;
  assign last_byte = (idx_q == IDX_W'(DATA_BYTES - 1));
  assign more      = byte_done & ~last_byte;
  // Either a fresh word or the next byte, chained in the last stop cycle
  assign start     = accept | more;

  always_comb begin
    sh_d   = sh_q;
    idx_d  = idx_q;
    cpb_d  = cpb_q;
    busy_d = busy_q;
    done_d = 1'b0;

    if (accept) begin
      sh_d   = result_i;
      idx_d  = '0;
      cpb_d  = (CLKS_PER_BIT == '0) ? CPB_WIDTH'(1) : CLKS_PER_BIT;
      busy_d = 1'b1;
    end else if (more) begin
      sh_d  = sh_q >> 8;
      idx_d = idx_q + IDX_W'(1);
    end else if (byte_done) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      idx_q  <= '0;
      cpb_q  <= CPB_WIDTH'(1);
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      idx_q  <= idx_d;
      cpb_q  <= cpb_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // On accept the serialiser counts against cpb_q from the next cycle on,
  // by which time cpb_q already holds the sampled value.
  uart_tx_byte #(
    .CPB_WIDTH (CPB_WIDTH)
  ) u_byte (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .byte_i  (sh_d[7:0]),
    .cpb_i   (cpb_q),
    .tx_o    (tx_o),
    .busy_o  (),
    .done_o  (byte_done)
  );

  assign result_ready_o = ~busy_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule
